// File: rtl/sw_debounce_pkg.sv
// Shared types and default constants for the slide-switch debouncer.
package sw_debounce_pkg;

    typedef enum logic {
        DB_IDLE = 1'b0,
        DB_QUAL = 1'b1
    } db_state_t;

    localparam int SW_WIDTH_DEF         = 10;
    localparam int SW_STABLE_CYCLES_DEF = 500000;

endpackage : sw_debounce_pkg

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchronizer, stability counter, debounced level
// and registered rise/fall pulses.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = SW_STABLE_CYCLES_DEF,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic sw_raw,
    output logic sw_db,
    output logic sw_rise,
    output logic sw_fall
);

    localparam int              CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1, s2;
    db_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             db_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, just like the hardware.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            s1      <= RESET_VAL;
            s2      <= RESET_VAL;
            sw_db   <= RESET_VAL;
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
            state   <= DB_IDLE;
            cnt     <= '0;
        end else begin
            s1      <= sw_raw;
            s2      <= s1;
            sw_db   <= db_nxt;
            sw_rise <= db_nxt & ~sw_db;
            sw_fall <= ~db_nxt & sw_db;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        db_nxt    = sw_db;
        unique case (state)
            DB_IDLE: begin
                cnt_nxt = '0;
                if (s2 != sw_db) begin
                    state_nxt = DB_QUAL;
                    cnt_nxt   = CNT_ONE;
                end
            end
            DB_QUAL: begin
                if (s2 == sw_db) begin
                    state_nxt = DB_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    db_nxt    = s2;
                    state_nxt = DB_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = DB_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule : sw_debounce_bit

// File: rtl/sw_debounce.sv
// Slide-switch debouncer: WIDTH independent bit debouncers. Optional sticky
// change flags and IRQ are built when SW_DEBOUNCE_IRQ_EN is defined.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int               WIDTH         = SW_WIDTH_DEF,
    parameter int               STABLE_CYCLES = SW_STABLE_CYCLES_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
`ifdef SW_DEBOUNCE_IRQ_EN
   ,output logic [WIDTH-1:0] sw_chg,
    output logic             sw_irq,
    input  logic             sw_irq_clr
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VAL     (RESET_VAL[i])
        ) u_bit (
            .clk_clk     (clk_clk),
            .reset_reset (reset_reset),
            .sw_raw      (sw_raw[i]),
            .sw_db       (sw_db[i]),
            .sw_rise     (sw_rise[i]),
            .sw_fall     (sw_fall[i])
        );
    end

`ifdef SW_DEBOUNCE_IRQ_EN
    // A clear and a new edge in the same cycle keep that bit set.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sw_chg <= '0;
        end else begin
            sw_chg <= (sw_irq_clr ? '0 : sw_chg) | sw_rise | sw_fall;
        end
    end

    assign sw_irq = |sw_chg;
`endif

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with WIDTH=10, STABLE_CYCLES=4, RESET_VAL=0.
// The IRQ scenario runs only when SW_DEBOUNCE_IRQ_EN is defined.
module tb_sw_debounce;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_db, sw_rise, sw_fall;
`ifdef SW_DEBOUNCE_IRQ_EN
    logic [W-1:0] sw_chg;
    logic         sw_irq;
    logic         sw_irq_clr;
`endif

    int n_cmp = 0;
    int n_err = 0;

    sw_debounce #(
        .WIDTH         (W),
        .STABLE_CYCLES (4),
        .RESET_VAL     ('0)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .sw_raw      (sw_raw),
        .sw_db       (sw_db),
        .sw_rise     (sw_rise),
        .sw_fall     (sw_fall)
`ifdef SW_DEBOUNCE_IRQ_EN
       ,.sw_chg      (sw_chg),
        .sw_irq      (sw_irq),
        .sw_irq_clr  (sw_irq_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_low();
        sw_raw = '0;
        repeat (10) step();
        check("settle_db", 32'(sw_db), 32'h0);
    endtask

    logic [W-1:0] acc;
    int           rise_cnt, fall_cnt, rise_edge;
    logic         pat;

    initial begin
        rst    = 1'b1;
        sw_raw = '0;
`ifdef SW_DEBOUNCE_IRQ_EN
        sw_irq_clr = 1'b0;
`endif

        // Reset state, then 20 quiet cycles.
        repeat (3) step();
        check("rst_db",   32'(sw_db),   32'h0);
        check("rst_rise", 32'(sw_rise), 32'h0);
        check("rst_fall", 32'(sw_fall), 32'h0);
`ifdef SW_DEBOUNCE_IRQ_EN
        check("rst_chg", 32'(sw_chg), 32'h0);
        check("rst_irq", 32'(sw_irq), 32'h0);
`endif
        rst = 1'b0;
        acc = '0;
        repeat (20) begin
            step();
            acc = acc | sw_db | sw_rise | sw_fall;
        end
        check("quiet_any", 32'(acc), 32'h0);

        // Bit 3 rise: sw_db changes at edge 5, pulse for one cycle.
        sw_raw[3] = 1'b1;
        acc = '0;
        repeat (5) begin
            step();
            acc = acc | sw_db | sw_rise;
        end
        check("b3_early", 32'(acc), 32'h0);
        step();
        check("b3_db",   32'(sw_db),   32'h008);
        check("b3_rise", 32'(sw_rise), 32'h008);
        check("b3_fall", 32'(sw_fall), 32'h000);
        step();
        check("b3_rise_end", 32'(sw_rise), 32'h000);
        check("b3_db_hold",  32'(sw_db),   32'h008);
        settle_low();

        // Bit 0 bounce 1,0,1,0 (2 cycles each) then 1: single rise at edge 13.
        rise_cnt  = 0;
        fall_cnt  = 0;
        rise_edge = -1;
        for (int e = 0; e < 20; e++) begin
            pat = (e < 8) ? (((e / 2) % 2) == 0) : 1'b1;
            sw_raw[0] = pat;
            step();
            if (sw_rise[0]) begin
                rise_cnt++;
                rise_edge = e;
            end
            if (sw_fall != '0) fall_cnt++;
        end
        check("bnc_rise_cnt",  32'(rise_cnt),  32'd1);
        check("bnc_rise_edge", 32'(rise_edge), 32'd13);
        check("bnc_fall_cnt",  32'(fall_cnt),  32'd0);
        check("bnc_db",        32'(sw_db),     32'h001);
        settle_low();

        // All bits high, then all low together.
        sw_raw = '1;
        repeat (6) step();
        check("all_db",   32'(sw_db),   32'h3FF);
        check("all_rise", 32'(sw_rise), 32'h3FF);
        step();
        sw_raw = '0;
        repeat (5) step();
        check("all_db_hold", 32'(sw_db),   32'h3FF);
        check("all_nofall",  32'(sw_fall), 32'h000);
        step();
        check("all_db_low", 32'(sw_db),   32'h000);
        check("all_fall",   32'(sw_fall), 32'h3FF);
        step();
        check("all_fall_end", 32'(sw_fall), 32'h000);
        repeat (5) step();

        // Bit 5: reset two cycles into qualification, then requalify.
        sw_raw[5] = 1'b1;
        acc = '0;
        repeat (4) begin
            step();
            acc = acc | sw_db | sw_rise;
        end
        rst = 1'b1;
        #1;
        acc = acc | sw_db | sw_rise;
        check("b5_pre_rst", 32'(acc), 32'h0);
        repeat (2) step();
        check("b5_in_rst", 32'(sw_db), 32'h0);
        rst = 1'b0;
        acc = '0;
        repeat (5) begin
            step();
            acc = acc | sw_db | sw_rise;
        end
        check("b5_early", 32'(acc), 32'h0);
        step();
        check("b5_db",   32'(sw_db),   32'h020);
        check("b5_rise", 32'(sw_rise), 32'h020);
        settle_low();

`ifdef SW_DEBOUNCE_IRQ_EN
        // Sticky flags: clear history, bit 7 rise, then clear collides with bit 2 rise.
        sw_irq_clr = 1'b1;
        step();
        sw_irq_clr = 1'b0;
        check("irq_clr0_chg", 32'(sw_chg), 32'h0);
        check("irq_clr0_irq", 32'(sw_irq), 32'h0);
        sw_raw[7] = 1'b1;
        repeat (7) step();
        check("irq_b7_chg", 32'(sw_chg), 32'h080);
        check("irq_b7_irq", 32'(sw_irq), 32'h1);
        sw_raw[2] = 1'b1;
        repeat (6) step();
        check("irq_b2_rise", 32'(sw_rise), 32'h004);
        sw_irq_clr = 1'b1;
        step();
        sw_irq_clr = 1'b0;
        check("irq_set_wins_chg", 32'(sw_chg), 32'h004);
        check("irq_set_wins_irq", 32'(sw_irq), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sw_debounce
